// File: rtl/hwcounter_reader.sv
// hwcounter_reader: coherent 64-bit counter sample read as hi, lo, hi over AXI-Lite, retrying lo/hi until hi is stable
// Ports:
//   m_axi_aclk, rst          clock and synchronous active-high reset
//   req_valid / req_ready    request one sample
//   m_axi_ar* / m_axi_r*     AXI-Lite read master, one read outstanding at a time
//   out_data, out_retry_cnt  sample {hi,lo} and retries used (saturates at 15)
//   out_err                  sample flagged by a non-OKAY read response
//   out_valid / out_ready    result handshake
// Optional: define HWCOUNTER_READER_RESP_CHECK_EN to end a sample early with out_err=1 on any non-OKAY rresp.
module hwcounter_reader #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 3,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_LO_OFFSET = 3'b000,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_HI_OFFSET = 3'b100
) (
  input  logic                            m_axi_aclk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  output logic [2*C_M_AXI_DATA_WIDTH-1:0] out_data,
  output logic [3:0]                      out_retry_cnt,
  output logic                            out_err,
  output logic                            out_valid,
  input  logic                            out_ready
);
  typedef enum logic [2:0] {IDLE, AR_HI1, R_HI1, AR_LO, R_LO, AR_HI2, R_HI2, DONE} state_t;
  state_t state_q;
  logic req_ready_q, arvalid_q, rready_q, out_valid_q, rd_err;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] hi1_q, lo_q;
  logic [2*C_M_AXI_DATA_WIDTH-1:0] out_data_q;
  logic [3:0] retry_q;
  assign req_ready     = req_ready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_rready  = rready_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_retry_cnt = retry_q;
`ifdef HWCOUNTER_READER_RESP_CHECK_EN
  logic err_q;
  assign rd_err  = m_axi_rresp != 2'b00;
  assign out_err = err_q;
  always_ff @(posedge m_axi_aclk)
    if (rst) err_q <= 1'b0;
    else if (state_q == IDLE && req_valid && req_ready_q) err_q <= 1'b0;
    else if (rready_q && m_axi_rvalid && rd_err) err_q <= 1'b1;
`else
  logic unused_rresp;
  assign unused_rresp = ^m_axi_rresp;
  assign rd_err  = 1'b0;
  assign out_err = 1'b0;
`endif
  always_ff @(posedge m_axi_aclk)
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      araddr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      retry_q     <= '0;
      hi1_q       <= '0;
      lo_q        <= '0;
    end else
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            retry_q     <= '0;
            arvalid_q   <= 1'b1;
            araddr_q    <= C_HI_OFFSET;
            state_q     <= AR_HI1;
          end
        end
        AR_HI1, AR_LO, AR_HI2:
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= state_q == AR_HI1 ? R_HI1 : state_q == AR_LO ? R_LO : R_HI2;
          end
        R_HI1, R_LO, R_HI2:
          if (m_axi_rvalid) begin
            rready_q <= 1'b0;
            if (rd_err) begin
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (state_q == R_LO) begin
              lo_q      <= m_axi_rdata;
              arvalid_q <= 1'b1;
              araddr_q  <= C_HI_OFFSET;
              state_q   <= AR_HI2;
            end else if (state_q == R_HI1 || m_axi_rdata != hi1_q) begin
              // hi moved between the two hi reads: the lo word may straddle a carry, so re-read lo
              hi1_q     <= m_axi_rdata;
              retry_q   <= retry_q + {3'b000, state_q == R_HI2 && retry_q != 4'hF};
              arvalid_q <= 1'b1;
              araddr_q  <= C_LO_OFFSET;
              state_q   <= AR_LO;
            end else begin
              out_data_q  <= {hi1_q, lo_q};
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        DONE:
          if (out_ready) begin
            out_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
      endcase
endmodule

// File: tb/tb_hwcounter_reader.sv
// tb_hwcounter_reader: scripted AXI-Lite slave, scoreboard of expected samples, and decoupled output monitor
module tb_hwcounter_reader;
  localparam logic [2:0] HI = 3'b100, LO = 3'b000;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_ready;
  logic [2:0] araddr;
  logic arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;
  logic [1:0] rresp = '0;
  logic [63:0] out_data;
  logic [3:0] retry;
  logic out_err, out_valid, out_ready = 1'b0;
  always #5 clk = ~clk;
  hwcounter_reader dut (
    .m_axi_aclk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .out_data(out_data), .out_retry_cnt(retry), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  typedef struct {logic [31:0] data; logic [2:0] addr; logic [1:0] resp; int ard; int rd;} rd_t;
  typedef struct {logic [63:0] data; logic [3:0] retry; logic err; int lat; int hold; int reads; int acc;} exp_t;
  rd_t build[$], script[$], rcur, rr;
  exp_t expq[$], cur;
  int tests = 0, fails = 0, cyc = 0, reads_total = 0, reads_exp = 0;
  logic [63:0] last_data = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask
  // slave: each AR pops the next scripted read; junk rvalid/arready outside the channel's active phase
  int ar_cnt = 0, r_cnt = 0;
  logic ar_fire = 1'b0, r_pend = 1'b0, ar_have = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      arready = 1'b0; rvalid = 1'b0; ar_fire = 1'b0; r_pend = 1'b0; ar_have = 1'b0; ar_cnt = 0;
    end else begin
      if (ar_fire) begin ar_fire = 1'b0; r_pend = 1'b1; r_cnt = 0; end
      chk("ar_r_overlap", arvalid && rready, 1'b0);
      arready = arvalid ? 1'b0 : 1'($urandom);
      rvalid = rready ? 1'b0 : 1'($urandom);
      rdata = $urandom;
      rresp = 2'($urandom);
      if (arvalid) begin
        if (!ar_have) begin
          if (script.size() == 0) begin
            chk("extra_read", 1'b1, 1'b0);
            rcur.data = '0; rcur.addr = araddr; rcur.resp = '0; rcur.ard = 0; rcur.rd = 0;
          end else rcur = script.pop_front();
          ar_have = 1'b1;
        end
        chk("araddr", araddr, rcur.addr);
        if (ar_cnt >= rcur.ard) begin
          arready = 1'b1; ar_fire = 1'b1; ar_cnt = 0; ar_have = 1'b0; rr = rcur; reads_total++;
        end else ar_cnt++;
      end else if (ar_have) begin
        chk("arvalid_held", arvalid, 1'b1);
        ar_have = 1'b0; ar_cnt = 0;
      end
      if (r_pend) begin
        if (r_cnt >= rr.rd) begin
          rvalid = 1'b1; rdata = rr.data; rresp = rr.resp;
          if (rready) r_pend = 1'b0;
        end else r_cnt++;
      end
    end
  end
  // monitor: compares each presented sample against the scoreboard head
  logic showing = 1'b0, fired = 1'b0, drain = 1'b0;
  int held = 0;
  logic [63:0] first_data;
  always @(negedge clk) begin
    if (rst) begin
      showing = 1'b0; fired = 1'b0; out_ready = 1'b0;
    end else begin
      drain = 1'b0;
      if (fired) begin
        chk("post_done_valid", out_valid, 1'b0);
        chk("post_done_req_ready", req_ready, 1'b1);
        fired = 1'b0;
      end else if (showing) begin
        chk("valid_held", out_valid, 1'b1);
        chk("data_held", out_data, first_data);
        chk("req_ready_in_done", req_ready, 1'b0);
      end else if (out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 1'b0);
          drain = 1'b1;
        end else begin
          cur = expq[0]; showing = 1'b1; held = 0; first_data = out_data;
          chk("out_data", out_data, cur.data);
          chk("out_retry_cnt", retry, cur.retry);
          chk("out_err", out_err, cur.err);
          chk("latency", cyc - cur.acc, cur.lat);
          chk("read_count", reads_total, cur.reads);
          chk("req_ready_at_valid", req_ready, 1'b0);
        end
      end
      out_ready = drain;
      if (showing) begin
        if (held < cur.hold) held++;
        else begin
          out_ready = 1'b1; void'(expq.pop_front()); showing = 1'b0; fired = 1'b1;
        end
      end
    end
  end
  task automatic push_rd(input logic [31:0] d, input logic hi, input int ard = 0, input int rd = 0);
    rd_t e;
    e.data = d; e.addr = hi ? HI : LO; e.resp = 2'b00; e.ard = ard; e.rd = rd;
    build.push_back(e);
  endtask
  task automatic accept();
    int t = 0;
    req_valid = 1'b1;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    if (!req_ready) begin chk("req_accept_timeout", req_ready, 1'b1); summary(); end
  endtask
  // expected latency: each read costs an AR cycle and an R cycle plus any slave wait
  task automatic issue(input logic [63:0] d, input int rt, input int eidx, input int hold);
    exp_t e;
    int t = 0;
    logic er = 1'b0;
    if (eidx >= 0) begin
      build[eidx].resp = 2'b10;
`ifdef HWCOUNTER_READER_RESP_CHECK_EN
      while (build.size() > eidx + 1) void'(build.pop_back());
      er = 1'b1; d = last_data; rt = eidx == 0 ? 0 : (eidx - 1) / 2;
`endif
    end
    e.lat = 0;
    foreach (build[i]) begin
      e.lat += 2 + build[i].ard + build[i].rd;
      script.push_back(build[i]);
    end
    reads_exp += build.size();
    build.delete();
    e.data = d; e.retry = 4'(rt > 15 ? 15 : rt); e.err = er; e.hold = hold; e.reads = reads_exp;
    if (!er) last_data = d;
    accept();
    e.acc = cyc + 1;
    expq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    while (expq.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    if (expq.size() != 0) begin chk("completion_timeout", expq.size(), 0); summary(); end
    @(negedge clk);
  endtask
  task automatic gen_random(input int r, input int eidx, input int dmax, input int hold);
    logic [31:0] h, lo, hn;
    logic [63:0] d = '0;
    h = $urandom;
    push_rd(h, 1'b1, $urandom_range(0, dmax), $urandom_range(0, dmax));
    for (int k = 0; k <= r; k++) begin
      lo = $urandom;
      push_rd(lo, 1'b0, $urandom_range(0, dmax), $urandom_range(0, dmax));
      hn = k < r ? h + $urandom_range(1, 3) : h;
      push_rd(hn, 1'b1, $urandom_range(0, dmax), $urandom_range(0, dmax));
      if (k == r) d = {h, lo};
      h = hn;
    end
    issue(d, r, eidx, hold);
  endtask
  task automatic check_reset_outputs();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_araddr", araddr, 3'b000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_retry", retry, 4'h0);
    chk("rst_err", out_err, 1'b0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", req_ready, 1'b1);
    push_rd(32'd5, 1'b1); push_rd(32'h1234_5678, 1'b0); push_rd(32'd5, 1'b1);
    issue(64'h0000_0005_1234_5678, 0, -1, 0);
    push_rd(32'd5, 1'b1); push_rd(32'hFFFF_FFFE, 1'b0); push_rd(32'd6, 1'b1);
    push_rd(32'h10, 1'b0); push_rd(32'd6, 1'b1);
    issue(64'h0000_0006_0000_0010, 1, -1, 0);
    push_rd(32'd7, 1'b1); push_rd(32'hAB, 1'b0, 3, 0); push_rd(32'd7, 1'b1);
    issue(64'h0000_0007_0000_00AB, 0, -1, 0);
    push_rd(32'h9, 1'b1); push_rd(32'hCAFE, 1'b0); push_rd(32'h9, 1'b1);
    issue(64'h0000_0009_0000_CAFE, 0, -1, 5);
    push_rd(32'd5, 1'b1); push_rd(32'h1234, 1'b0); push_rd(32'd5, 1'b1);
    issue(64'h0000_0005_0000_1234, 0, 1, 0);
    push_rd(32'h9, 1'b1); push_rd(32'h55, 1'b0, 0, 40); push_rd(32'h9, 1'b1);
    foreach (build[i]) script.push_back(build[i]);
    build.delete();
    accept();
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!(rready && araddr == LO) && t < 100) begin @(negedge clk); t++; end
    chk("reached_r_lo", rready && araddr == LO, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    script.delete();
    reads_exp = reads_total;
    last_data = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_mid_rst", req_ready, 1'b1);
    push_rd(32'h3, 1'b1); push_rd(32'h777, 1'b0); push_rd(32'h3, 1'b1);
    issue(64'h0000_0003_0000_0777, 0, -1, 1);
    gen_random(17, -1, 0, 0);
    for (int n = 0; n < 40; n++) begin
      int r, e;
      r = $urandom_range(0, 3);
      e = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 2 * r + 2)) : -1;
      gen_random(r, e, 2, $urandom_range(0, 3));
    end
    summary();
  end
endmodule

// File: doc/hwcounter_reader.md
HWCOUNTER_READER -- requirements
Module: hwcounter_reader

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI-Lite read data width; only 32 is supported.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 3, AXI-Lite read address width.
REQ-003 SHALL have parameter C_LO_OFFSET, default 3'b000, address of counter bits [31:0].
REQ-004 SHALL have parameter C_HI_OFFSET, default 3'b100, address of counter bits [63:32].
REQ-005 SHALL have port m_axi_aclk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req_valid, input, 1, request for one 64-bit counter sample.
REQ-008 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both high.
REQ-009 SHALL have port m_axi_araddr, output, C_M_AXI_ADDR_WIDTH, read address.
REQ-010 SHALL have ports m_axi_arvalid (output, 1) and m_axi_arready (input, 1), the AR handshake.
REQ-011 SHALL have ports m_axi_rdata (input, 32) and m_axi_rresp (input, 2), read data and response.
REQ-012 SHALL have ports m_axi_rvalid (input, 1) and m_axi_rready (output, 1), the R handshake.
REQ-013 SHALL have port out_data, output, 64, the coherent counter sample.
REQ-014 SHALL have port out_retry_cnt, output, 4, retries used for this sample, saturating at 15.
REQ-015 SHALL have port out_err, output, 1, error flag for this sample.
REQ-016 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.

Function
REQ-017 SHALL implement the states IDLE, AR_HI1, R_HI1, AR_LO, R_LO, AR_HI2, R_HI2 and DONE.
REQ-018 SHALL assert req_ready only in IDLE; on acceptance it SHALL clear the retry count and error flag and go to AR_HI1.
REQ-019 SHALL, in each AR_* state, drive m_axi_arvalid=1 with the state's offset (HI1/HI2: C_HI_OFFSET; LO: C_LO_OFFSET).
REQ-020 SHALL hold m_axi_araddr and m_axi_arvalid stable until m_axi_arready=1, then move to the matching R_* state the next cycle.
REQ-021 SHALL deassert m_axi_arvalid in every other state.
REQ-022 SHALL assert m_axi_rready only in R_* states and SHALL capture m_axi_rdata on m_axi_rvalid & m_axi_rready.
REQ-023 SHALL store the R_HI1 capture into hi1 and the R_LO capture into lo.
REQ-024 SHALL, in R_HI2, go to DONE with out_data={hi1,lo} when the captured word equals hi1.
REQ-025 SHALL, in R_HI2, load hi1 with the captured word, increment the retry count (saturating at 15) and return to AR_LO when the word differs from hi1.
REQ-026 SHALL hold out_valid=1 with out_data, out_retry_cnt and out_err stable in DONE until out_ready=1, then return to IDLE the next cycle.
REQ-027 SHALL set minimum latency, with zero-wait slave handshakes, to 6 cycles from request acceptance to out_valid.
REQ-028 SHALL have only one AXI read outstanding at any time; AR and R never overlap.
REQ-029 SHALL ignore m_axi_rvalid outside R_* states and m_axi_arready outside AR_* states.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, enter IDLE and drive req_ready=0, m_axi_arvalid=0, m_axi_rready=0, m_axi_araddr=0, out_valid=0, out_data=0, out_retry_cnt=0 and out_err=0.
REQ-031 SHALL assert req_ready=1 on the first cycle after rst deasserts.
REQ-032 SHALL abandon any transaction in progress when rst asserts mid-operation; no output pulse occurs.

Configuration
REQ-033 SHALL, with HWCOUNTER_READER_RESP_CHECK_EN defined, latch out_err=1 and go to DONE on any capture with m_axi_rresp!=2'b00, keeping out_data at its last value.
REQ-034 SHALL, without HWCOUNTER_READER_RESP_CHECK_EN, ignore m_axi_rresp, tie out_err to 0 and omit the error logic.

Verification
REQ-035 SHALL cover a stable counter 64'h0000_0005_1234_5678 with a zero-wait slave -> reads at 4,0,4; out_data=64'h0000000512345678; out_retry_cnt=0; out_valid 6 cycles after acceptance.
REQ-036 SHALL cover a rollover case, hi1=5, lo=32'hFFFF_FFFE, hi2=6, then lo=32'h10, hi=6 -> reads at 4,0,4,0,4; out_data=64'h0000000600000010; out_retry_cnt=1.
REQ-037 SHALL cover m_axi_arready delayed 3 cycles on the LO read -> m_axi_arvalid=1 and m_axi_araddr=0 held for all 4 cycles; no early rready.
REQ-038 SHALL cover out_ready low for 5 cycles in DONE -> out_valid and out_data held; req_ready=0 throughout.
REQ-039 SHALL cover rst pulsed in R_LO -> all outputs at reset values next cycle; the next request completes correctly.
REQ-040 SHALL cover, with the macro defined, m_axi_rresp=2'b10 on the LO read -> out_err=1 and out_valid=1, skipping HI2; without the macro -> out_err=0 and a normal completion.
